// File: rtl/mem_bus_arbiter_if.sv
// Request/bus signal bundle for mem_bus_arbiter: the arbiter takes the slave side, the
// requesters and the external memory bus together form the master side.
interface mem_bus_arbiter_if #(
  parameter int unsigned PHYSICAL_ADDRESS_SIZE = 56,
  parameter int unsigned DATA_WIDTH            = 64
);
  logic [1:0]                       req;
  logic [1:0]                       reqWrite;
  logic [PHYSICAL_ADDRESS_SIZE-1:0] reqAddr0;
  logic [PHYSICAL_ADDRESS_SIZE-1:0] reqAddr1;
  logic [DATA_WIDTH-1:0]            reqWdata0;
  logic [DATA_WIDTH-1:0]            reqWdata1;
  logic [1:0]                       grant;
  logic [1:0]                       done;
  logic [DATA_WIDTH-1:0]            rdata;
  logic [PHYSICAL_ADDRESS_SIZE-1:0] addrBus;
  logic [DATA_WIDTH-1:0]            dataOut;
  logic [DATA_WIDTH-1:0]            dataIn;
  logic                             doBusWrite;

  modport slave (
    input  req, reqWrite, reqAddr0, reqAddr1, reqWdata0, reqWdata1, dataIn,
    output grant, done, rdata, addrBus, dataOut, doBusWrite
  );

  modport master (
    output req, reqWrite, reqAddr0, reqAddr1, reqWdata0, reqWdata1, dataIn,
    input  grant, done, rdata, addrBus, dataOut, doBusWrite
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-port main-memory bus arbiter with a fixed-latency bus model and round-robin arbitration.
// Define MEM_ARB_FIXED_PRIORITY_EN to make port 1 always win contention instead.
module mem_bus_arbiter #(
  parameter int unsigned PHYSICAL_ADDRESS_SIZE = 56,
  parameter int unsigned DATA_WIDTH            = 64,
  parameter int unsigned MEM_LATENCY           = 4
) (
  input logic             clk,
  input logic             rst,
  mem_bus_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e                           state;
  logic [7:0]                       cnt;
  logic                             pick;
  logic                             selWrite;
  logic [PHYSICAL_ADDRESS_SIZE-1:0] selAddr;
  logic [DATA_WIDTH-1:0]            selWdata;

`ifndef MEM_ARB_FIXED_PRIORITY_EN
  logic rrPtr;  // 1 = port 1 favoured on contention
`endif

  always_comb begin
`ifdef MEM_ARB_FIXED_PRIORITY_EN
    pick = bus.req[1];
`else
    pick = (bus.req == 2'b11) ? rrPtr : bus.req[1];
`endif
    selAddr  = pick ? bus.reqAddr1  : bus.reqAddr0;
    selWdata = pick ? bus.reqWdata1 : bus.reqWdata0;
    selWrite = pick ? bus.reqWrite[1] : bus.reqWrite[0];
  end

  // Bus outputs double as the latched request, so they are loaded once at the grant edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= StIdle;
      cnt            <= '0;
      bus.grant      <= '0;
      bus.done       <= '0;
      bus.rdata      <= '0;
      bus.addrBus    <= '0;
      bus.dataOut    <= '0;
      bus.doBusWrite <= 1'b0;
`ifndef MEM_ARB_FIXED_PRIORITY_EN
      rrPtr          <= 1'b0;
`endif
    end else begin
      unique case (state)
        StIdle: begin
          if (bus.req != 2'b00) begin
            state          <= StBusy;
            cnt            <= 8'(MEM_LATENCY - 1);
            bus.grant      <= pick ? 2'b10 : 2'b01;
            bus.addrBus    <= selAddr;
            bus.dataOut    <= selWrite ? selWdata : '0;
            bus.doBusWrite <= selWrite;
`ifndef MEM_ARB_FIXED_PRIORITY_EN
            rrPtr          <= ~pick;
`endif
          end
        end
        StBusy: begin
          if (cnt == 8'd0) begin
            if (!bus.doBusWrite) begin
              bus.rdata <= bus.dataIn;
            end
            state          <= StDone;
            bus.done       <= bus.grant;
            bus.addrBus    <= '0;
            bus.dataOut    <= '0;
            bus.doBusWrite <= 1'b0;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        StDone: begin
          state     <= StIdle;
          bus.done  <= '0;
          bus.grant <= '0;
        end
        default: begin
          state     <= StIdle;
          bus.done  <= '0;
          bus.grant <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: transaction-level timing model checked every cycle plus
// directed scenarios with literal expectations, and a MEM_LATENCY=1 instance.
module tb_mem_bus_arbiter;
  localparam int unsigned AW = 56;
  localparam int unsigned DW = 64;
  localparam int L = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_bus_arbiter_if #(.PHYSICAL_ADDRESS_SIZE(AW), .DATA_WIDTH(DW)) bus  ();
  mem_bus_arbiter_if #(.PHYSICAL_ADDRESS_SIZE(AW), .DATA_WIDTH(DW)) bus1 ();

  mem_bus_arbiter #(.PHYSICAL_ADDRESS_SIZE(AW), .DATA_WIDTH(DW), .MEM_LATENCY(L)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  mem_bus_arbiter #(.PHYSICAL_ADDRESS_SIZE(AW), .DATA_WIDTH(DW), .MEM_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: edge k is the grant edge mG -> busy after edges mG..mG+L-1, done after mG+L,
  // idle after mG+L+1, next grant possible at edge mG+L+2.
  int             k = 0;
  bit             mValid = 0;
  bit             mActive = 0;
  int             mG = 0;
  int             mFree = 0;
  bit             mOwn = 0;
  bit             mPtr = 0;
  bit             mWr = 0;
  logic [AW-1:0]  mAddr = '0;
  logic [DW-1:0]  mWd = '0;
  logic [DW-1:0]  mRdata = '0;

  function automatic bit winner(input logic [1:0] r, input bit p);
    if (r == 2'b01) return 1'b0;
    if (r == 2'b10) return 1'b1;
`ifdef MEM_ARB_FIXED_PRIORITY_EN
    return 1'b1 | (p & 1'b0);
`else
    return p;
`endif
  endfunction

  always @(posedge clk) begin
    k <= k + 1;
    if (rst) begin
      mValid  <= 1'b1;
      mActive <= 1'b0;
      mPtr    <= 1'b0;
      mRdata  <= '0;
      mFree   <= k + 2;
    end else begin
      if (mActive && (k + 1 == mG + L) && !mWr) mRdata <= bus.dataIn;
      if ((k + 1 >= mFree) && (bus.req != 2'b00)) begin
        mOwn    <= winner(bus.req, mPtr);
        mPtr    <= !winner(bus.req, mPtr);
        mActive <= 1'b1;
        mG      <= k + 1;
        mFree   <= k + 1 + L + 2;
        mWr     <= bus.reqWrite[winner(bus.req, mPtr)];
        mAddr   <= winner(bus.req, mPtr) ? bus.reqAddr1 : bus.reqAddr0;
        mWd     <= winner(bus.req, mPtr) ? bus.reqWdata1 : bus.reqWdata0;
      end
    end
  end

  function automatic bit mBusy();
    return mActive && (k >= mG) && (k < mG + L);
  endfunction
  function automatic bit mDone();
    return mActive && (k == mG + L);
  endfunction
  function automatic logic [1:0] mOneHot();
    return mOwn ? 2'b10 : 2'b01;
  endfunction

  always @(negedge clk) begin
    if (mValid) begin
      chk("grant", bus.grant, (mBusy() || mDone()) ? mOneHot() : 2'b00);
      chk("done", bus.done, mDone() ? mOneHot() : 2'b00);
      chk("rdata", bus.rdata, mRdata);
      chk("addrBus", bus.addrBus, mBusy() ? mAddr : '0);
      chk("dataOut", bus.dataOut, (mBusy() && mWr) ? mWd : '0);
      chk("doBusWrite", bus.doBusWrite, mBusy() && mWr);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Runs one access on port p; counts busy cycles and cycles showing the request on the bus.
  task automatic access(input int p, input bit wr, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wd, input logic [DW-1:0] rd,
                        output int busy, output int addrCnt, output int wrCnt,
                        output logic [1:0] dv);
    bit got;
    got = 0; busy = 0; addrCnt = 0; wrCnt = 0; dv = 2'b00;
    bus.reqWrite[p] = wr;
    if (p == 0) begin bus.reqAddr0 = addr; bus.reqWdata0 = wd; end
    else        begin bus.reqAddr1 = addr; bus.reqWdata1 = wd; end
    bus.dataIn = 64'h5555_5555_5555_5555;
    bus.req[p] = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (bus.done != 2'b00) begin
        dv = bus.done; got = 1;
        break;
      end
      if (bus.grant != 2'b00) begin
        busy++;
        if (bus.addrBus == addr) addrCnt++;
        if (bus.doBusWrite && bus.dataOut == wd) wrCnt++;
        if (busy == 2) begin
          if (p == 0) begin bus.reqAddr0 = ~addr; bus.reqWdata0 = ~wd; end
          else        begin bus.reqAddr1 = ~addr; bus.reqWdata1 = ~wd; end
        end
        if (busy == L) bus.dataIn = rd;
      end
    end
    chk("access_timeout", got, 1'b1);
    bus.req[p] = 1'b0;
  endtask

  int          busy, addrCnt, wrCnt, n, idleGrants;
  logic [1:0]  dv;
  int          dTick [4];
  logic [1:0]  dVal [4];
  logic [1:0]  expOrder [4];
  bit          got;

  initial begin
    bus.req = '0; bus.reqWrite = '0; bus.reqAddr0 = '0; bus.reqAddr1 = '0;
    bus.reqWdata0 = '0; bus.reqWdata1 = '0; bus.dataIn = '0;
    bus1.req = '0; bus1.reqWrite = '0; bus1.reqAddr0 = '0; bus1.reqAddr1 = '0;
    bus1.reqWdata0 = '0; bus1.reqWdata1 = '0; bus1.dataIn = '0;

    // Reset and idle
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    chk("rst_grant", bus.grant, 2'b00);
    chk("rst_done", bus.done, 2'b00);
    chk("rst_rdata", bus.rdata, 64'h0);
    chk("rst_addr", bus.addrBus, 64'h0);
    chk("rst_wr", bus.doBusWrite, 1'b0);
    idleGrants = 0;
    repeat (10) begin
      tick();
      if (bus.grant != 2'b00) idleGrants++;
    end
    chk("idle_grants", idleGrants, 0);

    // Port 0 read
    access(0, 1'b0, 56'h1000, 64'h0, 64'hDEAD_BEEF, busy, addrCnt, wrCnt, dv);
    chk("rd0_latency", busy, 4);
    chk("rd0_addr_cycles", addrCnt, 4);
    chk("rd0_done", dv, 2'b01);
    chk("rd0_rdata", bus.rdata, 64'hDEAD_BEEF);
    bus.dataIn = '0;
    repeat (3) tick();
    chk("rd0_rdata_hold", bus.rdata, 64'hDEAD_BEEF);

    // Port 1 write
    access(1, 1'b1, 56'h20, 64'hCAFE, 64'h1234, busy, addrCnt, wrCnt, dv);
    chk("wr1_latency", busy, 4);
    chk("wr1_wr_cycles", wrCnt, 4);
    chk("wr1_addr_cycles", addrCnt, 4);
    chk("wr1_done", dv, 2'b10);
    chk("wr1_rdata_kept", bus.rdata, 64'hDEAD_BEEF);
    repeat (3) tick();

    // Both ports requesting continuously
    bus.reqWrite = 2'b00; bus.reqAddr0 = 56'h100; bus.reqAddr1 = 56'h200;
    bus.req = 2'b11;
    n = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (bus.done != 2'b00) begin
        dTick[n] = i; dVal[n] = bus.done; n++;
        if (n == 4) begin bus.req = 2'b00; break; end
      end
    end
    chk("both_count", n, 4);
`ifdef MEM_ARB_FIXED_PRIORITY_EN
    expOrder = '{2'b10, 2'b10, 2'b10, 2'b10};
`else
    expOrder = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif
    for (int i = 0; i < 4; i++) chk("both_order", dVal[i], expOrder[i]);
    for (int i = 1; i < 4; i++) chk("both_spacing", dTick[i] - dTick[i-1], L + 2);
    repeat (3) tick();

    // Reset in the 2nd BUSY cycle
    bus.reqAddr0 = 56'h3000; bus.req = 2'b01;
    tick();
    chk("abort_granted", bus.grant, 2'b01);
    tick();
    rst = 1'b1; bus.req = 2'b00;
    tick();
    chk("abort_grant", bus.grant, 2'b00);
    chk("abort_addr", bus.addrBus, 64'h0);
    chk("abort_wr", bus.doBusWrite, 1'b0);
    chk("abort_done", bus.done, 2'b00);
    rst = 1'b0; bus.req = 2'b11;
    tick();
`ifdef MEM_ARB_FIXED_PRIORITY_EN
    chk("after_rst_first", bus.grant, 2'b10);
`else
    chk("after_rst_first", bus.grant, 2'b01);
`endif
    got = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.done != 2'b00) begin got = 1; break; end
    end
    chk("after_rst_done", got, 1'b1);
    bus.req = 2'b00;
    repeat (3) tick();

    // MEM_LATENCY = 1 instance
    bus1.reqAddr0 = 56'h40; bus1.dataIn = 64'h77; bus1.req = 2'b01;
    tick();
    chk("l1_grant", bus1.grant, 2'b01);
    chk("l1_addr", bus1.addrBus, 64'h40);
    chk("l1_busy_done", bus1.done, 2'b00);
    tick();
    chk("l1_done", bus1.done, 2'b01);
    chk("l1_done_grant", bus1.grant, 2'b01);
    chk("l1_done_addr", bus1.addrBus, 64'h0);
    chk("l1_rdata", bus1.rdata, 64'h77);
    bus1.req = 2'b00;
    tick();
    chk("l1_idle_grant", bus1.grant, 2'b00);
    chk("l1_idle_done", bus1.done, 2'b00);
    repeat (2) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single main-memory bus between two requesters:
  - port 0: instruction-side L2 refill.
  - port 1: data-side (load/store) path.
- Sits between the L2 cache / data path and the external bus (addrBus, dataIn, dataOut, doBusWrite).
- Serialises accesses with a fixed-latency bus timing model and round-robin arbitration.
- Returns read data and a one-cycle completion pulse to the granted requester.

Parameters:
- PHYSICAL_ADDRESS_SIZE, 56, physical address width.
- DATA_WIDTH, 64, bus data width.
- MEM_LATENCY, 4, cycles the bus is held per access; legal range 1..255.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  2  per-port access request; hold high until that port's done.
- reqWrite  input  2  per-port: 1 = write, 0 = read; stable while req high.
- reqAddr0  input  PHYSICAL_ADDRESS_SIZE  port 0 address.
- reqAddr1  input  PHYSICAL_ADDRESS_SIZE  port 1 address.
- reqWdata0  input  DATA_WIDTH  port 0 write data.
- reqWdata1  input  DATA_WIDTH  port 1 write data.
- grant  output  2  one-hot; the port currently owning the bus (BUSY and DONE).
- done  output  2  one-hot, one-cycle completion pulse.
- rdata  output  DATA_WIDTH  read data of the last completed read; holds until the next read completes.
- addrBus  output  PHYSICAL_ADDRESS_SIZE  bus address.
- dataOut  output  DATA_WIDTH  bus write data.
- dataIn  input  DATA_WIDTH  bus read data.
- doBusWrite  output  1  bus write strobe.

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE.
  - Round-robin pointer favours port 0.
  - Latency counter 0.
  - rst mid-access aborts it: no done pulse, bus outputs 0 the next cycle.
- State IDLE:
  - Bus outputs 0; grant 0.
  - On an edge with req != 0: select the port, latch addr/write/wdata, set grant, counter = MEM_LATENCY-1, go to BUSY.
- Arbitration:
  - Exactly one request: that port wins.
  - Both requesting: the port the pointer favours wins.
  - After any grant, the pointer favours the other port.
- State BUSY:
  - addrBus = latched address.
  - dataOut = latched wdata if write, else 0.
  - doBusWrite = latched write.
  - Each edge: counter==0 → capture dataIn into rdata (reads only), go to DONE; else counter decrements.
  - BUSY lasts exactly MEM_LATENCY cycles.
- State DONE:
  - Bus outputs 0; done[g]=1 for this single cycle; grant still asserted.
  - Requester drops req at the edge ending DONE.
  - Next state IDLE unconditionally; req is not sampled in DONE.
- Latency:
  - Grant edge to done-high cycle: MEM_LATENCY cycles.
  - Back-to-back accesses from the same port: MEM_LATENCY+2 cycles apart.
- Latched request values are not affected by changes on reqAddr/reqWdata during BUSY.
- req dropped before done: the access still completes and done still pulses; the requester ignores it.
- Write completion leaves rdata unchanged.

Optional Feature:
- Macro: MEM_ARB_FIXED_PRIORITY_EN.
- Defined:
  - Port 1 (data side) always wins when both request.
  - Pointer logic removed.
  - Port 0 can starve; accepted for this mode.
- Undefined: round-robin as specified above.
- All other timing identical in both modes.

Test Plan:
- Reset, then idle with req=0: all outputs 0; 10 cycles idle with no grant.
- Port 0 read of 0x1000, MEM_LATENCY=4, dataIn=0xDEADBEEF during the 4th BUSY cycle:
  - addrBus=0x1000 for exactly 4 cycles.
  - done=2'b01 on cycle 4 after the grant edge.
  - rdata=0xDEADBEEF, held afterwards.
- Port 1 write of 0xCAFE to 0x20:
  - doBusWrite=1 and dataOut=0xCAFE for 4 cycles.
  - done=2'b10.
  - rdata unchanged.
- Both ports requesting continuously after reset:
  - Grants alternate 01, 10, 01, 10.
  - Each done spaced 6 cycles apart.
  - With MEM_ARB_FIXED_PRIORITY_EN, only port 1 is granted.
- rst asserted in the 2nd BUSY cycle:
  - Next cycle grant=0, addrBus=0, doBusWrite=0.
  - No done pulse.
  - Next request is served by port 0 first.
- MEM_LATENCY=1 with a port 0 read: BUSY one cycle, done on the cycle after the grant edge.
